// File: rtl/dotprod_pkg.sv
// dotprod_pkg: shared constants, FSM encodings and helpers for the dotprod scheduler.
package dotprod_pkg;
    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 1024;
    localparam int WDOG_DEF  = 4096;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    function automatic logic kern_owns(input logic [2:0] s);
        return s != ST_IDLE;
    endfunction
endpackage

// File: rtl/dotprod_sched_sram_port_mux.sv
// sram_port_mux: hands one single-port SRAM to the host in IDLE and to the kernel otherwise.
module sram_port_mux
    import dotprod_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic [2:0]    i_state,
    input  logic          i_h_ce,
    input  logic          i_h_we,
    input  logic [AW-1:0] i_h_addr,
    input  logic [DW-1:0] i_h_d,
    input  logic          i_k_ce,
    input  logic [AW-1:0] i_k_addr,
    output logic          o_ce,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_d
);
    logic w_kern;
    always_comb begin
        w_kern = kern_owns(i_state);
        o_ce   = w_kern ? i_k_ce : i_h_ce;
        o_we   = w_kern ? 1'b0 : (i_h_ce & i_h_we);
        o_addr = w_kern ? i_k_addr : i_h_addr;
        o_d    = w_kern ? '0 : i_h_d;
    end
endmodule

// File: rtl/dotprod_sched.sv
// dotprod_sched: launch sequencer, watchdog and SRAM arbiter for the dotprod kernel.
module dotprod_sched
    import dotprod_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int WDOG  = WDOG_DEF
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_bank,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_rvalid,
    input  logic          cmd_start,
    input  logic [AW-1:0] cmd_n,
    output logic          cmd_busy,
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    output logic          res_err,
    output logic          k_start,
    output logic [AW-1:0] k_n,
    input  logic          k_done,
    input  logic [DW-1:0] k_return,
    input  logic [AW-1:0] k_a_addr,
    input  logic [AW-1:0] k_b_addr,
    input  logic          k_a_ce,
    input  logic          k_b_ce,
    output logic [DW-1:0] k_a_q,
    output logic [DW-1:0] k_b_q,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          a_ce,
    output logic          a_we,
    output logic          b_ce,
    output logic          b_we,
    output logic [DW-1:0] a_d,
    output logic [DW-1:0] b_d,
    input  logic [DW-1:0] a_q,
    input  logic [DW-1:0] b_q
);
    localparam logic [AW-1:0] L_DEPTH     = AW'(DEPTH);
    localparam logic [31:0]   L_WDOG_LAST = 32'(WDOG - 1);

    logic [2:0]    r_state;
    logic [AW-1:0] r_n;
    logic [AW-1:0] r_k_n;
    logic          r_k_start;
    logic          r_err;
    logic [DW-1:0] r_res;
    logic [31:0]   r_wdog;
    logic          r_rvalid;
    logic          r_rbank;
    logic          r_rzero;

    logic w_idle;
    logic w_gnt;
    logic w_in_range;
    logic w_h_ce_a;
    logic w_h_ce_b;
    logic w_bad_n;

    // A launch request in the same cycle as host_req wins; the host waits for IDLE.
    always_comb begin
        w_idle     = r_state == ST_IDLE;
        w_gnt      = host_req & w_idle & ~cmd_start;
        w_in_range = host_addr < L_DEPTH;
        w_h_ce_a   = w_gnt & w_in_range & (host_bank == BANK_A);
        w_h_ce_b   = w_gnt & w_in_range & (host_bank == BANK_B);
        w_bad_n    = r_n > L_DEPTH;
    end

    assign host_gnt    = w_gnt;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = (r_rvalid & ~r_rzero) ? (r_rbank ? b_q : a_q) : '0;
    assign cmd_busy    = (r_state == ST_CHECK) | (r_state == ST_START) | (r_state == ST_RUN);
    assign res_valid   = r_state == ST_DONE;
    assign res_data    = r_res;
    assign res_err     = r_err;
    assign k_start     = r_k_start;
    assign k_n         = r_k_n;
    assign k_a_q       = a_q;
    assign k_b_q       = b_q;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state   <= ST_IDLE;
            r_n       <= '0;
            r_k_n     <= '0;
            r_k_start <= 1'b0;
            r_err     <= 1'b0;
            r_res     <= '0;
            r_wdog    <= '0;
            r_rvalid  <= 1'b0;
            r_rbank   <= 1'b0;
            r_rzero   <= 1'b0;
        end else begin
            r_rvalid <= w_gnt & ~host_we;
            if (w_gnt) begin
                r_rbank <= host_bank;
                r_rzero <= ~w_in_range;
            end
            case (r_state)
                ST_IDLE: if (cmd_start) begin
                    r_state <= ST_CHECK;
                    r_n     <= cmd_n;
                    r_err   <= 1'b0;
                end
                ST_CHECK: if (r_n == '0 || w_bad_n) begin
                    r_state <= ST_DONE;
                    r_res   <= '0;
                    r_err   <= w_bad_n;
                end else begin
                    r_state   <= ST_START;
                    r_k_n     <= r_n;
                    r_k_start <= 1'b1;
                end
                ST_START: begin
                    r_state <= ST_RUN;
                    r_wdog  <= '0;
                end
                ST_RUN: if (k_done) begin
                    r_state   <= ST_DONE;
                    r_res     <= k_return;
                    r_k_start <= 1'b0;
                end else if (r_wdog == L_WDOG_LAST) begin
                    r_state   <= ST_DONE;
                    r_res     <= '0;
                    r_err     <= 1'b1;
                    r_k_start <= 1'b0;
                end else begin
                    r_wdog <= r_wdog + 32'd1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sram_port_mux #(.AW(AW), .DW(DW)) u_mux_a (
        .i_state (r_state),
        .i_h_ce  (w_h_ce_a),
        .i_h_we  (host_we),
        .i_h_addr(host_addr),
        .i_h_d   (host_wdata),
        .i_k_ce  (k_a_ce),
        .i_k_addr(k_a_addr),
        .o_ce    (a_ce),
        .o_we    (a_we),
        .o_addr  (a_addr),
        .o_d     (a_d)
    );

    sram_port_mux #(.AW(AW), .DW(DW)) u_mux_b (
        .i_state (r_state),
        .i_h_ce  (w_h_ce_b),
        .i_h_we  (host_we),
        .i_h_addr(host_addr),
        .i_h_d   (host_wdata),
        .i_k_ce  (k_b_ce),
        .i_k_addr(k_b_addr),
        .o_ce    (b_ce),
        .o_we    (b_we),
        .o_addr  (b_addr),
        .o_d     (b_d)
    );
endmodule

// File: tb/tb_dotprod_sched.sv
// tb_dotprod_sched: directed bench with SRAM models and a dotprod kernel stub.
module tb_dotprod_sched;
    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        host_req = 1'b0, host_we = 1'b0, host_bank = 1'b0;
    logic [31:0] host_addr = '0, host_wdata = '0;
    logic        host_gnt, host_rvalid;
    logic [31:0] host_rdata;
    logic        cmd_start = 1'b0;
    logic [31:0] cmd_n = '0;
    logic        cmd_busy, res_valid, res_err, k_start;
    logic [31:0] res_data, k_n;
    logic        k_done;
    logic [31:0] k_return;
    logic [31:0] k_a_addr, k_b_addr, k_a_q, k_b_q;
    logic        k_a_ce, k_b_ce;
    logic [31:0] a_addr, b_addr, a_d, b_d;
    logic [31:0] a_q = '0, b_q = '0;
    logic        a_ce, a_we, b_ce, b_we;

    always #5 ap_clk = ~ap_clk;

    dotprod_sched #(.WDOG(16)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .host_req(host_req), .host_we(host_we), .host_bank(host_bank),
        .host_addr(host_addr), .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .cmd_start(cmd_start), .cmd_n(cmd_n), .cmd_busy(cmd_busy),
        .res_data(res_data), .res_valid(res_valid), .res_err(res_err),
        .k_start(k_start), .k_n(k_n), .k_done(k_done), .k_return(k_return),
        .k_a_addr(k_a_addr), .k_b_addr(k_b_addr), .k_a_ce(k_a_ce), .k_b_ce(k_b_ce),
        .k_a_q(k_a_q), .k_b_q(k_b_q),
        .a_addr(a_addr), .b_addr(b_addr), .a_ce(a_ce), .a_we(a_we),
        .b_ce(b_ce), .b_we(b_we), .a_d(a_d), .b_d(b_d), .a_q(a_q), .b_q(b_q)
    );

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    always @(posedge ap_clk) begin
        if (a_ce) begin
            if (a_we) mem_a[a_addr[9:0]] <= a_d;
            a_q <= mem_a[a_addr[9:0]];
        end
        if (b_ce) begin
            if (b_we) mem_b[b_addr[9:0]] <= b_d;
            b_q <= mem_b[b_addr[9:0]];
        end
    end

    // kernel stub: streams A[i]*B[i] for i<k_n, then pulses ap_done; k_hang makes it never finish
    logic        k_hang = 1'b0, k_done_f = 1'b0, kd_r, kv;
    logic [31:0] k_ret_f = '0, kret_r, kidx, kacc;
    logic [1:0]  kph;
    assign k_done   = kd_r | k_done_f;
    assign k_return = k_done_f ? k_ret_f : kret_r;
    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            kph <= 2'd0; kd_r <= 1'b0; kret_r <= '0; kidx <= '0; kacc <= '0; kv <= 1'b0;
            k_a_ce <= 1'b0; k_b_ce <= 1'b0; k_a_addr <= '0; k_b_addr <= '0;
        end else begin
            kd_r <= 1'b0;
            kv   <= k_a_ce;
            if (kph == 2'd0) begin
                if (k_start && !k_hang) begin kph <= 2'd1; kidx <= '0; kacc <= '0; end
            end else if (kph == 2'd1) begin
                if (kv) kacc <= kacc + k_a_q * k_b_q;
                if (kidx < k_n) begin
                    k_a_addr <= kidx; k_b_addr <= kidx; k_a_ce <= 1'b1; k_b_ce <= 1'b1;
                    kidx <= kidx + 32'd1;
                end else begin
                    k_a_ce <= 1'b0; k_b_ce <= 1'b0;
                    if (!k_a_ce && !kv) begin kd_r <= 1'b1; kret_r <= kacc; kph <= 2'd2; end
                end
            end else if (!k_start) begin
                kph <= 2'd0;
            end
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hacc(input logic we, input logic bank, input logic [31:0] addr, input logic [31:0] d,
                        output logic [31:0] rd, output logic rv, output logic ce, output logic gok);
        int k;
        host_req = 1'b1; host_we = we; host_bank = bank; host_addr = addr; host_wdata = d;
        #1;
        k = 0;
        while (!host_gnt && k < 20) begin @(posedge ap_clk); #1; k++; end
        gok = host_gnt;
        ce  = a_ce | b_ce;
        @(posedge ap_clk); #1;
        host_req = 1'b0; host_we = 1'b0;
        rd = host_rdata;
        rv = host_rvalid;
    endtask

    int pulses, ks_cycles, ks_rises, rise_c, lat_bad, hold_bad, gnt_bad, we_bad, gnt_cnt, rv_cnt;
    logic [31:0] rv_data, last_res;
    logic gnt_at_start, err_c0;

    task automatic launch(input logic [31:0] n, input int cycles, input int hr_at, input logic hr_we,
                          input logic [31:0] hr_addr, input logic [31:0] hr_d, input int cs2);
        logic gp, kdp, ksp, ks_seen;
        pulses = 0; ks_cycles = 0; ks_rises = 0; rise_c = -1; lat_bad = 0; hold_bad = 0;
        gnt_bad = 0; we_bad = 0; gnt_cnt = 0; rv_cnt = 0; rv_data = '0; last_res = '1; err_c0 = 1'b1;
        gp = 1'b0; kdp = 1'b0; ksp = 1'b0; ks_seen = 1'b0;
        cmd_n = n; cmd_start = 1'b1;
        if (hr_at == 0) begin
            host_req = 1'b1; host_we = hr_we; host_bank = 1'b0; host_addr = hr_addr; host_wdata = hr_d;
        end
        #1;
        gnt_at_start = host_gnt;
        for (int c = 0; c < cycles; c++) begin
            @(posedge ap_clk); #1;
            if (c == 0) begin cmd_start = 1'b0; err_c0 = res_err; end
            if (cs2 > 0 && c == cs2) begin cmd_start = 1'b1; cmd_n = '0; end
            if (cs2 > 0 && c == cs2 + 1) cmd_start = 1'b0;
            if (hr_at > 0 && c == hr_at) begin
                host_req = 1'b1; host_we = hr_we; host_bank = 1'b0; host_addr = hr_addr; host_wdata = hr_d;
            end
            if (gp) begin host_req = 1'b0; host_we = 1'b0; end
            if (host_rvalid) begin rv_cnt++; rv_data = host_rdata; end
            if (res_valid) begin pulses++; last_res = res_data; if (!kdp) lat_bad++; end
            if (k_start) ks_cycles++;
            if (k_start && !ksp) begin ks_rises++; rise_c = c; end
            if (k_start) ks_seen = 1'b1;
            if (cmd_busy && ks_seen && !k_start) hold_bad++;
            #1;
            if (host_gnt && (cmd_busy || res_valid)) gnt_bad++;
            if (host_gnt) gnt_cnt++;
            if (cmd_busy && (a_we || b_we)) we_bad++;
            gp = host_gnt; kdp = k_done; ksp = k_start;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic rv, ce, gok;
        int wbad;
        repeat (2) @(posedge ap_clk);
        #1;
        chk("rst_k_start", k_start, 0);
        chk("rst_cmd_busy", cmd_busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_k_n", k_n, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;

        wbad = 0;
        for (int i = 0; i < 10; i++) begin
            hacc(1'b1, 1'b0, 32'(i), 32'(i + 1), rd, rv, ce, gok);
            if (!gok || !ce) wbad++;
            hacc(1'b1, 1'b1, 32'(i), 32'(10 - i), rd, rv, ce, gok);
            if (!gok || !ce) wbad++;
        end
        chk("load_gnt_ce", wbad, 0);
        hacc(1'b0, 1'b0, 32'd3, 32'd0, rd, rv, ce, gok);
        chk("rd_a3_rvalid", rv, 1);
        chk("rd_a3_data", rd, 4);
        @(posedge ap_clk); #1;
        chk("rvalid_one_cycle", host_rvalid, 0);
        hacc(1'b0, 1'b1, 32'd3, 32'd0, rd, rv, ce, gok);
        chk("rd_b3_data", rd, 7);
        hacc(1'b1, 1'b0, 32'd1024, 32'd99, rd, rv, ce, gok);
        chk("oor_wr_gnt", gok, 1);
        chk("oor_wr_ce", ce, 0);
        hacc(1'b0, 1'b0, 32'd0, 32'd0, rd, rv, ce, gok);
        chk("rd_a0_intact", rd, 1);
        hacc(1'b0, 1'b1, 32'd2000, 32'd0, rd, rv, ce, gok);
        chk("oor_rd_rvalid", rv, 1);
        chk("oor_rd_data", rd, 0);

        launch(32'd10, 40, 0, 1'b0, 32'd5, 32'd0, 0);
        chk("l1_gnt_vs_start", gnt_at_start, 0);
        chk("l1_rise_cycle", rise_c, 1);
        chk("l1_rises", ks_rises, 1);
        chk("l1_hold", hold_bad, 0);
        chk("l1_pulses", pulses, 1);
        chk("l1_result", last_res, 220);
        chk("l1_done_latency", lat_bad, 0);
        chk("l1_err", res_err, 0);
        chk("l1_gnt_busy", gnt_bad, 0);
        chk("l1_gnt_after", gnt_cnt, 1);
        chk("l1_rv_cnt", rv_cnt, 1);
        chk("l1_rv_data", rv_data, 6);
        chk("l1_res_held", res_data, 220);

        launch(32'd0, 10, -1, 1'b0, 32'd0, 32'd0, 0);
        chk("n0_kstart", ks_cycles, 0);
        chk("n0_pulses", pulses, 1);
        chk("n0_result", last_res, 0);
        chk("n0_err", res_err, 0);

        launch(32'd1025, 10, -1, 1'b0, 32'd0, 32'd0, 0);
        chk("big_kstart", ks_cycles, 0);
        chk("big_pulses", pulses, 1);
        chk("big_err", res_err, 1);
        chk("big_result", last_res, 0);

        k_hang = 1'b1;
        launch(32'd10, 40, -1, 1'b0, 32'd0, 32'd0, 5);
        chk("wd_err_cleared", err_c0, 0);
        chk("wd_kstart_cycles", ks_cycles, 17);
        chk("wd_pulses", pulses, 1);
        chk("wd_err", res_err, 1);
        chk("wd_result", last_res, 0);
        k_ret_f = 32'd77; k_done_f = 1'b1;
        @(posedge ap_clk); #1;
        k_done_f = 1'b0;
        chk("late_done_valid", res_valid, 0);
        @(posedge ap_clk); #1;
        chk("late_done_data", res_data, 0);
        k_hang = 1'b0;

        launch(32'd10, 40, 3, 1'b1, 32'd20, 32'd5, 0);
        chk("l2_result", last_res, 220);
        chk("l2_gnt_busy", gnt_bad, 0);
        chk("l2_no_we_busy", we_bad, 0);
        chk("l2_gnt_after", gnt_cnt, 1);
        hacc(1'b0, 1'b0, 32'd20, 32'd0, rd, rv, ce, gok);
        chk("l2_host_write", rd, 5);

        cmd_n = 32'd10; cmd_start = 1'b1;
        @(posedge ap_clk); #1;
        cmd_start = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("mid_run_kstart", k_start, 1);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("arst_kstart", k_start, 0);
        chk("arst_busy", cmd_busy, 0);
        chk("arst_res_data", res_data, 0);
        chk("arst_k_n", k_n, 0);
        chk("arst_a_ce", a_ce, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        launch(32'd10, 40, -1, 1'b0, 32'd0, 32'd0, 0);
        chk("post_rst_pulses", pulses, 1);
        chk("post_rst_result", last_res, 220);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
